// File: rtl/axis_frame_checker.sv
// AXI4-Stream video sink that measures frame geometry against an expected size.
// Reports a completed or aborted frame with a one-cycle frame_done pulse, and keeps sticky error flags.
module axis_frame_checker #(
    parameter int DATA_W = 24,
    parameter int DIM_W  = 12
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,

    input  logic              enable,
    input  logic [DIM_W-1:0]  exp_width,
    input  logic [DIM_W-1:0]  exp_height,
    input  logic              clear,

    output logic              in_frame,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [DIM_W-1:0]  meas_width,
    output logic [DIM_W-1:0]  meas_height,
    output logic [15:0]       frame_count,
    output logic              err_eol_early,
    output logic              err_eol_late,
    output logic              err_sof_early,
    output logic [15:0]       discard_count
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DIM_W-1:0] r_pix_cnt;
    logic [DIM_W-1:0] r_line_cnt;
    logic [DIM_W-1:0] r_exp_w;
    logic [DIM_W-1:0] r_exp_h;
    logic [DIM_W-1:0] r_work_w;
    logic             r_frame_err;

    logic             r_frame_done;
    logic             r_frame_ok;
    logic [DIM_W-1:0] r_meas_w;
    logic [DIM_W-1:0] r_meas_h;
    logic [15:0]      r_frame_count;
    logic             r_err_eol_early;
    logic             r_err_eol_late;
    logic             r_err_sof_early;
    logic [15:0]      r_discard_count;

    logic             w_ready;
    logic             w_xfer;
    logic             w_sof;
    logic             w_beat_active;
    logic             w_abort;
    logic             w_discard;
    logic             w_eol;
    logic             w_early;
    logic             w_late;
    logic             w_complete;
    logic             w_done;

    logic [DIM_W-1:0] w_pix_inc;
    logic [DIM_W-1:0] w_cur_pix;
    logic [DIM_W-1:0] w_base_line;
    logic [DIM_W-1:0] w_line_next;
    logic [DIM_W-1:0] w_base_exp_w;
    logic [DIM_W-1:0] w_base_exp_h;
    logic [DIM_W-1:0] w_base_work_w;
    logic             w_base_err;
    logic [DIM_W-1:0] w_work_w_next;
    logic             w_err_next;

    logic             w_unused_tdata;

    assign w_unused_tdata = ^s_axis_tdata;

    // Handshake qualification
    assign w_ready       = enable & ~areset;
    assign w_xfer        = s_axis_tvalid & w_ready;
    assign w_sof         = w_xfer & s_axis_tuser;
    assign w_beat_active = w_xfer & ((r_state == S_ACTIVE) | s_axis_tuser);
    assign w_abort       = w_sof & (r_state == S_ACTIVE);
    assign w_discard     = w_xfer & ~s_axis_tuser & (r_state == S_IDLE);

    // An SOF beat evaluates against a freshly started frame, otherwise against the running one
    assign w_base_line   = w_sof ? '0         : r_line_cnt;
    assign w_base_exp_w  = w_sof ? exp_width  : r_exp_w;
    assign w_base_exp_h  = w_sof ? exp_height : r_exp_h;
    assign w_base_work_w = w_sof ? '0         : r_work_w;
    assign w_base_err    = w_sof ? 1'b0       : r_frame_err;

    assign w_pix_inc   = (r_pix_cnt == '1) ? r_pix_cnt : r_pix_cnt + DIM_W'(1);
    assign w_cur_pix   = w_sof ? DIM_W'(1) : w_pix_inc;
    assign w_line_next = (w_base_line == '1) ? w_base_line : w_base_line + DIM_W'(1);

    // Line end checks; a saturated line counter never reaches a zero height target
    assign w_eol         = w_beat_active & s_axis_tlast;
    assign w_early       = w_eol & (w_cur_pix < w_base_exp_w);
    assign w_late        = w_eol & (w_cur_pix > w_base_exp_w);
    assign w_work_w_next = (w_eol && (w_base_line == '0)) ? w_cur_pix : w_base_work_w;
    assign w_err_next    = w_base_err | w_early | w_late;
    assign w_complete    = w_eol & (w_line_next == w_base_exp_h);
    assign w_done        = w_abort | w_complete;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sof) begin
                    w_state_next = w_complete ? S_IDLE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_beat_active && w_complete) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-frame working registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_exp_w     <= '0;
            r_exp_h     <= '0;
            r_work_w    <= '0;
            r_frame_err <= 1'b0;
        end else if (w_beat_active) begin
            r_pix_cnt   <= w_eol ? '0 : w_cur_pix;
            r_line_cnt  <= w_eol ? w_line_next : w_base_line;
            r_exp_w     <= w_base_exp_w;
            r_exp_h     <= w_base_exp_h;
            r_work_w    <= w_work_w_next;
            r_frame_err <= w_err_next;
        end
    end

    // Frame reports; an abort and a same-beat 1x1 completion share one pulse, the abort wins
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_meas_w      <= '0;
            r_meas_h      <= '0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_done;
            if (w_done) begin
                r_frame_count <= r_frame_count + 16'd1;
                if (w_abort) begin
                    r_frame_ok <= 1'b0;
                    r_meas_w   <= r_work_w;
                    r_meas_h   <= r_line_cnt;
                end else begin
                    r_frame_ok <= ~w_err_next;
                    r_meas_w   <= w_work_w_next;
                    r_meas_h   <= w_base_exp_h;
                end
            end
        end
    end

    // Sticky status; a new event in the clear cycle survives the clear
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_sof_early <= 1'b0;
            r_discard_count <= '0;
        end else begin
            r_err_eol_early <= (r_err_eol_early & ~clear) | w_early;
            r_err_eol_late  <= (r_err_eol_late  & ~clear) | w_late;
            r_err_sof_early <= (r_err_sof_early & ~clear) | w_abort;
            if (clear) begin
                r_discard_count <= w_discard ? 16'd1 : 16'd0;
            end else if (w_discard && (r_discard_count != '1)) begin
                r_discard_count <= r_discard_count + 16'd1;
            end
        end
    end

    assign s_axis_tready = w_ready;
    assign in_frame      = (r_state == S_ACTIVE);
    assign frame_done    = r_frame_done;
    assign frame_ok      = r_frame_ok;
    assign meas_width    = r_meas_w;
    assign meas_height   = r_meas_h;
    assign frame_count   = r_frame_count;
    assign err_eol_early = r_err_eol_early;
    assign err_eol_late  = r_err_eol_late;
    assign err_sof_early = r_err_sof_early;
    assign discard_count = r_discard_count;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Scoreboard bench for axis_frame_checker: expected frame reports are queued as
// stimulus is driven and compared whenever the DUT pulses frame_done.
module tb_axis_frame_checker;

    localparam int DATA_W = 24;
    localparam int DIM_W  = 12;

    logic              aclk = 1'b0;
    logic              areset;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tuser;
    logic              s_axis_tlast;
    logic              enable;
    logic [DIM_W-1:0]  exp_width;
    logic [DIM_W-1:0]  exp_height;
    logic              clear;
    logic              in_frame;
    logic              frame_done;
    logic              frame_ok;
    logic [DIM_W-1:0]  meas_width;
    logic [DIM_W-1:0]  meas_height;
    logic [15:0]       frame_count;
    logic              err_eol_early;
    logic              err_eol_late;
    logic              err_sof_early;
    logic [15:0]       discard_count;

    typedef struct {
        logic        ok;
        int unsigned w;
        int unsigned h;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_fc;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          gaps = 1'b0;

    axis_frame_checker #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .enable        (enable),
        .exp_width     (exp_width),
        .exp_height    (exp_height),
        .clear         (clear),
        .in_frame      (in_frame),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .meas_width    (meas_width),
        .meas_height   (meas_height),
        .frame_count   (frame_count),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .err_sof_early (err_sof_early),
        .discard_count (discard_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push_exp(input logic ok, input int unsigned w, input int unsigned h);
        exp_t e;
        e.ok = ok;
        e.w  = w;
        e.h  = h;
        sb.push_back(e);
    endtask

    task automatic beat(input logic u, input logic l);
        int unsigned tries;
        logic        acc;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = DATA_W'($urandom);
        tries = 0;
        forever begin
            if (gaps) enable = ($urandom_range(0, 3) != 0);
            #1;
            acc = s_axis_tready;
            @(posedge aclk);
            #1;
            if (acc) break;
            tries++;
            if (tries >= 1000) begin
                chk("accept_timeout", 32'(tries), 0);
                break;
            end
        end
    endtask

    task automatic send_line(input int unsigned n, input logic sof);
        for (int unsigned i = 0; i < n; i++) begin
            beat(sof && (i == 0), i == n - 1);
        end
    endtask

    task automatic send_frame(input int unsigned w, input int unsigned h);
        for (int unsigned j = 0; j < h; j++) begin
            send_line(w, j == 0);
        end
    endtask

    task automatic settle();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        enable        = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_errs(input string tag, input logic e, input logic l, input logic s);
        chk({tag, "_eol_early"}, 32'(err_eol_early), 32'(e));
        chk({tag, "_eol_late"},  32'(err_eol_late),  32'(l));
        chk({tag, "_sof_early"}, 32'(err_sof_early), 32'(s));
    endtask

    always @(negedge aclk) begin
        if (frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(frame_done), 0);
            end else begin
                mon_e = sb.pop_front();
                exp_fc = exp_fc + 16'd1;
                chk("frame_ok",    32'(frame_ok),    32'(mon_e.ok));
                chk("meas_width",  32'(meas_width),  mon_e.w);
                chk("meas_height", 32'(meas_height), mon_e.h);
                chk("frame_count", 32'(frame_count), 32'(exp_fc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_fc        = '0;
        areset        = 1'b1;
        enable        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        clear         = 1'b0;
        exp_width     = 12'd4;
        exp_height    = 12'd3;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_in_frame", 32'(in_frame), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_discard", 32'(discard_count), 0);
        chk_errs("rst", 1'b0, 1'b0, 1'b0);
        areset = 1'b0;
        #1;
        chk("tready_enabled", 32'(s_axis_tready), 1);

        // Clean 4x3 frame
        push_exp(1'b1, 4, 3);
        beat(1'b1, 1'b0);
        chk("in_frame_after_sof", 32'(in_frame), 1);
        beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
        send_line(4, 1'b0);
        send_line(4, 1'b0);
        settle();
        chk("clean_in_frame", 32'(in_frame), 0);
        chk("clean_count", 32'(frame_count), 1);
        chk_errs("clean", 1'b0, 1'b0, 1'b0);

        // Discarded beats before SOF, then clear
        repeat (5) beat(1'b0, 1'b0);
        settle();
        chk("discard5", 32'(discard_count), 5);
        push_exp(1'b1, 4, 3);
        send_frame(4, 3);
        settle();
        chk("discard_hold", 32'(discard_count), 5);
        pulse_clear();
        chk("discard_clr", 32'(discard_count), 0);

        // Short second line
        push_exp(1'b0, 4, 3);
        send_line(4, 1'b1);
        send_line(3, 1'b0);
        send_line(4, 1'b0);
        settle();
        chk_errs("short", 1'b1, 1'b0, 1'b0);
        pulse_clear();
        chk_errs("short_clr", 1'b0, 1'b0, 1'b0);

        // Early SOF mid-line 2, then a clean frame
        send_line(4, 1'b1);
        beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        push_exp(1'b0, 4, 1);
        push_exp(1'b1, 4, 3);
        send_frame(4, 3);
        settle();
        chk_errs("abort", 1'b0, 1'b0, 1'b1);
        pulse_clear();

        // Larger frame with random tvalid/enable gaps
        exp_width  = 12'd64;
        exp_height = 12'd24;
        push_exp(1'b1, 64, 24);
        gaps = 1'b1;
        send_frame(64, 24);
        gaps = 1'b0;
        settle();
        chk_errs("gaps", 1'b0, 1'b0, 1'b0);

        // Zero expected size, 1x1 frame ending an overlong line, single-beat frame
        exp_width  = 12'd0;
        exp_height = 12'd0;
        send_line(2, 1'b1);
        settle();
        chk("zero_in_frame", 32'(in_frame), 1);
        exp_width  = 12'd1;
        exp_height = 12'd1;
        push_exp(1'b0, 2, 1);
        beat(1'b1, 1'b0);
        push_exp(1'b0, 2, 1);
        beat(1'b0, 1'b1);
        push_exp(1'b1, 1, 1);
        beat(1'b1, 1'b1);
        settle();
        chk("one_in_frame", 32'(in_frame), 0);
        chk_errs("bound", 1'b0, 1'b1, 1'b1);

        // Reset mid-frame, errors left set so reset must clear them
        exp_width  = 12'd4;
        exp_height = 12'd3;
        send_line(4, 1'b1);
        beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        #1;
        chk("mid_rst_tready", 32'(s_axis_tready), 0);
        @(posedge aclk);
        #1;
        exp_fc = '0;
        chk("mid_rst_in_frame", 32'(in_frame), 0);
        chk("mid_rst_count", 32'(frame_count), 0);
        chk("mid_rst_meas_w", 32'(meas_width), 0);
        chk("mid_rst_meas_h", 32'(meas_height), 0);
        chk("mid_rst_ok", 32'(frame_ok), 0);
        chk_errs("mid_rst", 1'b0, 1'b0, 1'b0);
        areset = 1'b0;
        push_exp(1'b1, 4, 3);
        send_frame(4, 3);
        settle();
        chk("post_rst_count", 32'(frame_count), 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
